// File: rtl/counter_key_ctrl_pkg.sv
// counter_key_ctrl_pkg: shared types and key priority ordering for the key-driven counter controller
package counter_key_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   typedef enum logic {KEY_UP, KEY_DOWN} key_t;

   // Key event priority: lower index wins when several keys rise in the same cycle
   localparam int PRIO_CLR  = 0;
   localparam int PRIO_LOAD = 1;
   localparam int PRIO_UP   = 2;
   localparam int PRIO_DOWN = 3;
   localparam int NUM_KEYS  = 4;

endpackage

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: hold-delay then periodic repeat tick generator for a held key
module key_repeat_timer #(
   parameter int HOLD_DELAY    = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic tick_o,
   output logic phase_o
);

   localparam int MAX_P = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int TW = $clog2(MAX_P + 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_DELAY - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_PERIOD - 1);

   logic [TW-1:0] timer;

   // phase_o low = waiting out the initial hold delay, high = repeating
   assign tick_o = enable_i && (timer == (phase_o ? REP_LAST : HOLD_LAST));

   // Count while enabled; every tick restarts the count in the repeat phase
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer   <= '0;
         phase_o <= 1'b0;
      end else if (clear_i) begin
         timer   <= '0;
         phase_o <= 1'b0;
      end else if (tick_o) begin
         timer   <= '0;
         phase_o <= 1'b1;
      end else if (enable_i) begin
         timer   <= timer + 1'b1;
      end
   end

endmodule

// File: rtl/counter_key_ctrl.sv
// counter_key_ctrl: key-event arbitration, hold-to-repeat FSM and wrap/saturate counter
module counter_key_ctrl
   import counter_key_ctrl_pkg::*;
#(
   parameter int COUNT_WIDTH   = 8,
   parameter int HOLD_DELAY    = 500,
   parameter int REPEAT_PERIOD = 100,
   parameter bit SATURATE      = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clr_i,
   input  logic                   load_i,
   input  logic [COUNT_WIDTH-1:0] load_val_i,
   input  logic                   up_i,
   input  logic                   down_i,
   output logic [COUNT_WIDTH-1:0] count_o,
   output logic                   step_o,
   output logic                   wrap_o,
   output logic                   dir_o
);

   logic [NUM_KEYS-1:0] key, prev, arm, ev;
   logic [1:0] win;
   state_t state, state_d;
   key_t held, held_d;
   logic [COUNT_WIDTH-1:0] count_d, inc_val, dec_val;
   logic step_d, wrap_d, dir_d, inc_wrap, dec_wrap, at_max, at_zero;
   logic held_lvl, tick, phase, tmr_clr, tmr_en;

   assign key[PRIO_CLR]  = clr_i;
   assign key[PRIO_LOAD] = load_i;
   assign key[PRIO_UP]   = up_i;
   assign key[PRIO_DOWN] = down_i;

   // A key must be seen low once after reset before it can raise an event,
   // so a key still held through reset does not fire on release of reset.
   assign ev = key & ~prev & arm;

   // Previous-level and arm registers for rising-edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev <= '0;
         arm  <= '0;
      end else begin
         prev <= key;
         arm  <= arm | ~key;
      end
   end

   // Pick the highest-priority rising key this cycle; the rest are dropped
   always_comb begin
      win = 2'(PRIO_DOWN);
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (ev[i]) win = 2'(i);
   end

   assign at_max   = &count_o;
   assign at_zero  = ~|count_o;
   assign inc_val  = (SATURATE && at_max) ? count_o : count_o + 1'b1;
   assign dec_val  = (SATURATE && at_zero) ? count_o : count_o - 1'b1;
   assign inc_wrap = !SATURATE && at_max;
   assign dec_wrap = !SATURATE && at_zero;
   assign held_lvl = (held == KEY_UP) ? up_i : down_i;

   // Next-state, next-count and step/wrap/direction decisions
   always_comb begin
      state_d = state;
      held_d  = held;
      count_d = count_o;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      dir_d   = dir_o;
      if (|ev && win == 2'(PRIO_CLR)) begin
         count_d = '0;
         step_d  = 1'b1;
         state_d = IDLE;
      end else if (|ev && win == 2'(PRIO_LOAD)) begin
         count_d = load_val_i;
         step_d  = 1'b1;
         state_d = IDLE;
      end else if (state == IDLE) begin
         if (|ev) begin
            held_d  = (win == 2'(PRIO_UP)) ? KEY_UP : KEY_DOWN;
            count_d = (win == 2'(PRIO_UP)) ? inc_val : dec_val;
            wrap_d  = (win == 2'(PRIO_UP)) ? inc_wrap : dec_wrap;
            dir_d   = (win == 2'(PRIO_UP));
            step_d  = 1'b1;
            state_d = HOLD;
         end
      end else if (!held_lvl) begin
         state_d = IDLE;
      end else begin
         state_d = (tick || phase) ? REPEAT : HOLD;
         if (tick) begin
            count_d = (held == KEY_UP) ? inc_val : dec_val;
            wrap_d  = (held == KEY_UP) ? inc_wrap : dec_wrap;
            step_d  = 1'b1;
         end
      end
   end

   // The timer restarts on entry to HOLD and whenever the FSM leaves the held states
   assign tmr_clr = (state == IDLE) || (state_d == IDLE);
   assign tmr_en  = (state != IDLE);

   key_repeat_timer #(
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (tmr_clr),
      .enable_i (tmr_en),
      .tick_o   (tick),
      .phase_o  (phase)
   );

   // State and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         held    <= KEY_UP;
         count_o <= '0;
         step_o  <= 1'b0;
         wrap_o  <= 1'b0;
         dir_o   <= 1'b1;
      end else begin
         state   <= state_d;
         held    <= held_d;
         count_o <= count_d;
         step_o  <= step_d;
         wrap_o  <= wrap_d;
         dir_o   <= dir_d;
      end
   end

endmodule

// File: tb/tb_counter_key_ctrl.sv
// tb_counter_key_ctrl: scoreboard bench for counter_key_ctrl (wrap and saturate instances)
module tb_counter_key_ctrl;

   typedef struct {
      int cnt;
      int wrap;
      int dir;
      int at;
   } exp_t;

   logic clk = 0, rst_n = 0;
   logic clr = 0, load = 0, up = 0, down = 0;
   logic s_load = 0, s_up = 0, s_down = 0;
   logic [3:0] load_val = 0;
   logic [3:0] count, s_count;
   logic step, wrap, dir, s_step, s_wrap, s_dir;

   int cyc = 0, n_cmp = 0, n_bad = 0, base = 0;
   int rel [6] = '{0, 10, 14, 18, 22, 26};
   exp_t q[$], qs[$];
   exp_t e, es;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   counter_key_ctrl #(.COUNT_WIDTH(4), .HOLD_DELAY(10), .REPEAT_PERIOD(4), .SATURATE(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
      .up_i(up), .down_i(down), .count_o(count), .step_o(step), .wrap_o(wrap), .dir_o(dir));

   counter_key_ctrl #(.COUNT_WIDTH(4), .HOLD_DELAY(10), .REPEAT_PERIOD(4), .SATURATE(1'b1)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0), .load_i(s_load), .load_val_i(load_val),
      .up_i(s_up), .down_i(s_down), .count_o(s_count), .step_o(s_step), .wrap_o(s_wrap), .dir_o(s_dir));

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(int c, int w, int d, int at);
      q.push_back('{c, w, d, at});
   endtask

   task automatic push_s(int c, int w, int d, int at);
      qs.push_back('{c, w, d, at});
   endtask

   // Monitor: every step pulse is matched against the next expected step
   always @(negedge clk) begin
      if (step) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_step: got step with count %0d at cycle %0d, expected none", count, cyc);
         end else begin
            e = q.pop_front();
            check("step_count", int'(count), e.cnt);
            check("step_wrap", int'(wrap), e.wrap);
            check("step_dir", int'(dir), e.dir);
            check("step_cycle", cyc, e.at);
         end
      end
      if (s_step) begin
         if (qs.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_sat_step: got step with count %0d at cycle %0d, expected none", s_count, cyc);
         end else begin
            es = qs.pop_front();
            check("sat_step_count", int'(s_count), es.cnt);
            check("sat_step_wrap", int'(s_wrap), es.wrap);
            check("sat_step_dir", int'(s_dir), es.dir);
            check("sat_step_cycle", cyc, es.at);
         end
      end
   end

   initial begin
      tick(3);
      rst_n = 1;
      tick(2);
      check("reset_count", int'(count), 0);
      check("reset_step", int'(step), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_dir", int'(dir), 1);

      // single tap
      up = 1;
      push(1, 0, 1, cyc + 1);
      tick(3);
      up = 0;
      tick(3);
      check("tap_count", int'(count), 1);

      // hold repeat from 0
      clr = 1;
      push(0, 0, 1, cyc + 1);
      tick();
      clr = 0;
      tick(2);
      up = 1;
      base = cyc + 1;
      for (int i = 0; i < 6; i++) push(i + 1, 0, 1, base + rel[i]);
      tick(30);
      up = 0;
      tick(3);
      check("hold_count", int'(count), 6);

      // wrap both ways
      load_val = 15;
      load = 1;
      push(15, 0, 1, cyc + 1);
      tick();
      load = 0;
      tick(2);
      up = 1;
      push(0, 1, 1, cyc + 1);
      tick();
      up = 0;
      tick(2);
      down = 1;
      push(15, 1, 0, cyc + 1);
      tick();
      down = 0;
      tick(2);

      // same sequence on the saturating instance
      s_load = 1;
      push_s(15, 0, 1, cyc + 1);
      tick();
      s_load = 0;
      tick(2);
      s_up = 1;
      push_s(15, 0, 1, cyc + 1);
      tick();
      s_up = 0;
      tick(2);
      s_down = 1;
      push_s(14, 0, 0, cyc + 1);
      tick();
      s_down = 0;
      tick(2);
      check("sat_count", int'(s_count), 14);

      // simultaneous events
      load_val = 3;
      load = 1;
      push(3, 0, 0, cyc + 1);
      tick();
      load = 0;
      tick(2);
      load_val = 9;
      clr = 1;
      load = 1;
      up = 1;
      push(0, 0, 0, cyc + 1);
      tick(3);
      clr = 0;
      load = 0;
      up = 0;
      tick(2);
      check("clr_prio_count", int'(count), 0);
      load = 1;
      up = 1;
      push(9, 0, 0, cyc + 1);
      tick(3);
      load = 0;
      up = 0;
      tick(2);
      check("load_prio_count", int'(count), 9);

      // cross-key: down ignored while up repeats
      up = 1;
      base = cyc + 1;
      for (int i = 0; i < 5; i++) push(10 + i, 0, 1, base + rel[i]);
      tick(16);
      down = 1;
      tick(8);
      up = 0;
      tick(2);
      check("cross_count", int'(count), 14);
      check("cross_dir_up", int'(dir), 1);
      down = 0;
      tick();
      down = 1;
      push(13, 0, 0, cyc + 1);
      tick();
      down = 0;
      tick(2);
      check("cross_dir_down", int'(dir), 0);

      // reset mid-repeat
      clr = 1;
      push(0, 0, 0, cyc + 1);
      tick();
      clr = 0;
      tick(2);
      up = 1;
      base = cyc + 1;
      for (int i = 0; i < 5; i++) push(i + 1, 0, 1, base + rel[i]);
      tick(24);
      check("pre_reset_count", int'(count), 5);
      #2 rst_n = 0;
      #1;
      check("async_reset_count", int'(count), 0);
      check("async_reset_step", int'(step), 0);
      check("async_reset_wrap", int'(wrap), 0);
      check("async_reset_dir", int'(dir), 1);
      tick(2);
      rst_n = 1;
      tick(30);
      check("held_through_reset_count", int'(count), 0);
      up = 0;
      tick(2);
      up = 1;
      push(1, 0, 1, cyc + 1);
      tick();
      up = 0;
      tick(3);
      check("repress_count", int'(count), 1);

      check("missing_steps", q.size(), 0);
      check("missing_sat_steps", qs.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
